// File: rtl/siteswap_loader.sv
// Collects siteswap digits, then checks divisibility (repeated subtraction) and landing collisions.
// Commit to DONE/ERROR within 8 + 7*14 cycles; digit/commit strobes are dropped while busy_out is high.
module siteswap_loader #(
  parameter int MAX_LEN = 7
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [2:0]               digit_in,
  input  logic                     digit_valid_in,
  input  logic                     commit_in,
  output logic [MAX_LEN-1:0][2:0]  pattern_out,
  output logic [2:0]               pattern_len_out,
  output logic [2:0]               num_balls_out,
  output logic                     pattern_valid_out,
  output logic                     error_out,
  output logic                     busy_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DIVIDE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0] LMAX = 3'(MAX_LEN);
  localparam logic [2:0] QMAX = 3'd7;

  state_t              r_state;
  state_t              w_state_nx;
  logic [2:0]          r_len;
  logic [5:0]          r_sum;
  logic [5:0]          r_rem;
  logic [2:0]          r_q;
  logic [2:0]          r_idx;
  logic [3:0]          r_land;
  logic [MAX_LEN-1:0]  r_mask;

  logic       w_open;
  logic       w_collect;
  logic       w_take;
  logic       w_ovf;
  logic       w_commit;
  logic [2:0] w_len_nx;
  logic [5:0] w_sum_nx;
  logic [5:0] w_sum_eff;
  logic       w_div_ge;
  logic       w_land_ge;
  logic       w_hit;
  logic       w_last;
  logic [2:0] w_idx_nx;
  logic [3:0] w_land_nx;

  assign w_open    = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_collect = (r_state == S_COLLECT);
  assign w_ovf     = digit_valid_in && w_collect && (r_len == LMAX);
  assign w_take    = digit_valid_in && (w_open || (w_collect && (r_len != LMAX)));
  // A commit with no digit outside COLLECT has nothing to validate.
  assign w_commit  = commit_in && ((w_collect && !w_ovf) || (w_open && digit_valid_in));
  assign w_len_nx  = w_open ? 3'd1 : (r_len + 3'd1);
  assign w_sum_nx  = w_open ? {3'b000, digit_in} : (r_sum + {3'b000, digit_in});
  assign w_sum_eff = w_take ? w_sum_nx : r_sum;

  assign w_div_ge  = (r_rem >= {3'b000, r_len});
  assign w_land_ge = (r_land >= {1'b0, r_len});
  assign w_hit     = r_mask[r_land[2:0]];
  assign w_last    = (r_idx == (r_len - 3'd1));
  assign w_idx_nx  = r_idx + 3'd1;
  assign w_land_nx = {1'b0, w_idx_nx} + {1'b0, pattern_out[w_idx_nx]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (digit_valid_in) begin
          w_state_nx = w_commit ? S_DIVIDE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_ovf) begin
          w_state_nx = S_ERROR;
        end else if (w_commit) begin
          w_state_nx = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (w_div_ge) begin
          if (r_q == QMAX) begin
            w_state_nx = S_ERROR;
          end
        end else begin
          w_state_nx = (r_rem != 6'd0) ? S_ERROR : S_CHECK;
        end
      end
      S_CHECK: begin
        if (!w_land_ge) begin
          if (w_hit) begin
            w_state_nx = S_ERROR;
          end else if (w_last) begin
            w_state_nx = S_DONE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pattern_valid_out = (r_state == S_DONE);
    error_out         = (r_state == S_ERROR);
    busy_out          = (r_state == S_DIVIDE) || (r_state == S_CHECK);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pattern_out     <= '0;
      pattern_len_out <= '0;
      num_balls_out   <= '0;
      r_len           <= '0;
      r_sum           <= '0;
      r_rem           <= '0;
      r_q             <= '0;
      r_idx           <= '0;
      r_land          <= '0;
      r_mask          <= '0;
    end else begin
      if (w_take) begin
        if (w_open) begin
          pattern_out    <= '0;
          pattern_out[0] <= digit_in;
        end else begin
          pattern_out[r_len] <= digit_in;
        end
        r_len <= w_len_nx;
        r_sum <= w_sum_nx;
      end
      if (w_commit) begin
        r_rem <= w_sum_eff;
        r_q   <= '0;
      end
      case (r_state)
        S_DIVIDE: begin
          if (w_div_ge) begin
            if (r_q != QMAX) begin
              r_rem <= r_rem - {3'b000, r_len};
              r_q   <= r_q + 3'd1;
            end
          end else begin
            r_idx  <= '0;
            r_mask <= '0;
            r_land <= {1'b0, pattern_out[0]};
          end
        end
        S_CHECK: begin
          if (w_land_ge) begin
            r_land <= r_land - {1'b0, r_len};
          end else if (!w_hit) begin
            r_mask[r_land[2:0]] <= 1'b1;
            if (w_last) begin
              pattern_len_out <= r_len;
              num_balls_out   <= r_q;
            end else begin
              r_idx  <= w_idx_nx;
              r_land <= w_land_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_siteswap_loader.sv
// Randomized and directed bench for siteswap_loader with a queue scoreboard and a spec-level model.
module tb_siteswap_loader;

  logic             clk_in;
  logic             rst_in;
  logic [2:0]       digit_in;
  logic             digit_valid_in;
  logic             commit_in;
  logic [6:0][2:0]  pattern_out;
  logic [2:0]       pattern_len_out;
  logic [2:0]       num_balls_out;
  logic             pattern_valid_out;
  logic             error_out;
  logic             busy_out;

  siteswap_loader #(.MAX_LEN(7)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .digit_in          (digit_in),
    .digit_valid_in    (digit_valid_in),
    .commit_in         (commit_in),
    .pattern_out       (pattern_out),
    .pattern_len_out   (pattern_len_out),
    .num_balls_out     (num_balls_out),
    .pattern_valid_out (pattern_valid_out),
    .error_out         (error_out),
    .busy_out          (busy_out)
  );

  typedef struct {
    logic            valid;
    logic            err;
    logic [2:0]      len;
    logic [2:0]      balls;
    logic [6:0][2:0] pat;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   m_last_len = 0;
  int   m_last_balls = 0;
  logic prev_flag = 1'b0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected result from the siteswap rules: divisible sum, distinct landing beats mod length.
  function automatic exp_t model(input int n, input int dig[8]);
    exp_t e;
    int   sum;
    bit   used[8];
    bit   bad_pat;
    e.pat = '0;
    for (int i = 0; i < n && i < 7; i++) e.pat[i] = 3'(dig[i]);
    bad_pat = 1'b0;
    sum = 0;
    for (int i = 0; i < 8; i++) used[i] = 1'b0;
    if (n > 7) begin
      bad_pat = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) sum += dig[i];
      if (sum % n != 0) bad_pat = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (used[(i + dig[i]) % n]) bad_pat = 1'b1;
        used[(i + dig[i]) % n] = 1'b1;
      end
    end
    if (bad_pat) begin
      e.valid = 1'b0;
      e.err   = 1'b1;
    end else begin
      e.valid = 1'b1;
      e.err   = 1'b0;
      m_last_len   = n;
      m_last_balls = sum / n;
    end
    e.len   = 3'(m_last_len);
    e.balls = 3'(m_last_balls);
    return e;
  endfunction

  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_flag = 1'b0;
    end else begin
      if ((pattern_valid_out | error_out) && !prev_flag) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(pattern_valid_out), 32'(1'bx));
        end else begin
          me = exp_q.pop_front();
          chk("valid", 32'(pattern_valid_out), 32'(me.valid));
          chk("error", 32'(error_out), 32'(me.err));
          chk("len", 32'(pattern_len_out), 32'(me.len));
          chk("balls", 32'(num_balls_out), 32'(me.balls));
          chk("pattern", 32'(pattern_out), 32'(me.pat));
        end
      end
      prev_flag = pattern_valid_out | error_out;
    end
  end

  task automatic step(input logic dv, input logic [2:0] d, input logic cm);
    digit_valid_in = dv;
    digit_in       = d;
    commit_in      = cm;
    @(posedge clk_in);
    #1;
    digit_valid_in = 1'b0;
    commit_in      = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (busy_out && k < 200) begin
      @(posedge clk_in);
      #1;
      k++;
    end
    chk("latency_bound", 32'(k <= 106), 32'd1);
    step(1'b0, 3'd0, 1'b0);
  endtask

  task automatic send(input int n, input int dig[8], input bit joint);
    exp_q.push_back(model(n, dig));
    for (int i = 0; i < n && i < 8; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 3'd0, 1'b0);
      step(1'b1, 3'(dig[i]), 1'(joint && (i == n - 1) && (n <= 7)));
    end
    if (n <= 7) begin
      if (!joint) step(1'b0, 3'd0, 1'b1);
      chk("busy_after_commit", 32'(busy_out), 32'd1);
      wait_done();
    end else begin
      step(1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pattern"}, 32'(pattern_out), 32'd0);
    chk({tag, "_len"}, 32'(pattern_len_out), 32'd0);
    chk({tag, "_balls"}, 32'(num_balls_out), 32'd0);
    chk({tag, "_flags"}, {29'd0, pattern_valid_out, error_out, busy_out}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int d[8];
    int p[8];
    int n;
    int j;
    int tmp;
    int mode;
    rst_in = 1'b1;
    digit_in = 3'd0;
    digit_valid_in = 1'b0;
    commit_in = 1'b0;
    #13;
    check_all_zero("reset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    step(1'b0, 3'd0, 1'b0);

    d = '{4, 4, 1, 0, 0, 0, 0, 0}; send(3, d, 1'b0);
    d = '{5, 3, 1, 0, 0, 0, 0, 0}; send(3, d, 1'b0);
    d = '{4, 3, 2, 0, 0, 0, 0, 0}; send(3, d, 1'b0);
    d = '{4, 5, 0, 0, 0, 0, 0, 0}; send(2, d, 1'b0);
    d = '{3, 3, 3, 3, 3, 3, 3, 3}; send(8, d, 1'b0);
    d = '{7, 7, 7, 7, 7, 7, 7, 0}; send(7, d, 1'b0);

    step(1'b0, 3'd0, 1'b1);
    chk("lone_commit_valid", 32'(pattern_valid_out), 32'd1);
    chk("lone_commit_busy", 32'(busy_out), 32'd0);
    chk("lone_commit_len", 32'(pattern_len_out), 32'd7);

    d = '{0, 0, 0, 0, 0, 0, 0, 0}; send(1, d, 1'b0);
    d = '{3, 0, 0, 0, 0, 0, 0, 0}; send(1, d, 1'b1);

    // Strobes while busy must not disturb the pattern under validation.
    d = '{4, 4, 1, 0, 0, 0, 0, 0};
    exp_q.push_back(model(3, d));
    for (int i = 0; i < 3; i++) step(1'b1, 3'(d[i]), 1'b0);
    step(1'b0, 3'd0, 1'b1);
    j = 0;
    while (busy_out && j < 200) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      j++;
    end
    chk("busy_bound", 32'(j < 200), 32'd1);
    step(1'b0, 3'd0, 1'b0);

    // Reset in the middle of CHECK.
    for (int i = 0; i < 3; i++) step(1'b1, 3'(d[i]), 1'b0);
    step(1'b0, 3'd0, 1'b1);
    repeat (6) step(1'b0, 3'd0, 1'b0);
    chk("abort_busy", 32'(busy_out), 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check_all_zero("abort");
    m_last_len = 0;
    m_last_balls = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    step(1'b0, 3'd0, 1'b0);
    d = '{3, 0, 0, 0, 0, 0, 0, 0}; send(1, d, 1'b0);

    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(0, 9);
      n = (mode == 0) ? 8 : $urandom_range(1, 7);
      for (int i = 0; i < 8; i++) d[i] = $urandom_range(0, 7);
      if (mode < 6 && n <= 7) begin
        for (int i = 0; i < n; i++) p[i] = i;
        for (int i = n - 1; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = p[i]; p[i] = p[j]; p[j] = tmp;
        end
        for (int i = 0; i < n; i++) begin
          d[i] = (p[i] - i + n) % n;
          while (d[i] + n <= 7 && $urandom_range(0, 1) == 1) d[i] += n;
        end
      end
      send(n, d, (n <= 7) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (3) step(1'b0, 3'd0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
